// File: rtl/mod12_updown_counter_if.sv
// Bundles the counter's control inputs and status outputs.
//   master : drives load/enable/up_down/data_in, observes the count and pulses
//   slave  : the counter itself
interface mod12_updown_counter_if #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
);
   logic              load;
   logic              enable;
   logic              up_down;
   logic [WIDTH-1:0]  data_in;
   logic [WIDTH-1:0]  data_out;
   logic              carry;
   logic              borrow;
   logic              load_err;
   logic [WRAP_W-1:0] wrap_count;
   logic              tc;

   modport master (
      output load, enable, up_down, data_in,
      input  data_out, carry, borrow, load_err, wrap_count, tc
   );

   modport slave (
      input  load, enable, up_down, data_in,
      output data_out, carry, borrow, load_err, wrap_count, tc
   );
endinterface

// File: rtl/mod12_updown_counter.sv
// Modulo-MODULUS up/down counter.
// It has a synchronous load, a count enable, registered carry/borrow/load_err
// pulses, a saturating tally of wraps, and a combinational terminal count.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of mod12_updown_counter_if
//           (load, enable, up_down, data_in in;
//            data_out, carry, borrow, load_err, wrap_count, tc out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// DIR_UP   | up_down=1: an enabled edge increments, MODULUS-1 -> 0 pulses carry
// DIR_DOWN | up_down=0: an enabled edge decrements, 0 -> MODULUS-1 pulses borrow
// The direction is decoded from up_down in every cycle and is never stored,
// so a change of direction applies on the very next enabled edge.
module mod12_updown_counter #(
   parameter int MODULUS = 12,
   parameter int WIDTH   = 4,
   parameter int WRAP_W  = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   mod12_updown_counter_if.slave         bus
);

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   // One extra bit so that MODULUS = 2^WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   dir_e              dir;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic              borrow_q, borrow_d;
   logic              lerr_q, lerr_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         lerr_q   <= 1'b0;
         wrap_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         lerr_q   <= lerr_d;
         wrap_q   <= wrap_d;
      end
   end

   always_comb begin
      dir      = bus.up_down ? DIR_UP : DIR_DOWN;
      cnt_d    = cnt_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      lerr_d   = 1'b0;
      if (bus.load) begin
         if ({1'b0, bus.data_in} < MOD_EXT) begin
            cnt_d = bus.data_in;
         end else begin
            cnt_d  = '0;
            lerr_d = 1'b1;
         end
      end else if (bus.enable) begin
         case (dir)
            DIR_UP: begin
               if (cnt_q == MAX_VAL) begin
                  cnt_d   = '0;
                  carry_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               if (cnt_q == '0) begin
                  cnt_d    = MAX_VAL;
                  borrow_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         endcase
      end
      // The tally saturates at all-ones and never rolls over.
      wrap_d = wrap_q;
      if ((carry_d || borrow_d) && (wrap_q != '1)) begin
         wrap_d = wrap_q + 1'b1;
      end
   end

   always_comb begin
      bus.data_out   = cnt_q;
      bus.carry      = carry_q;
      bus.borrow     = borrow_q;
      bus.load_err   = lerr_q;
      bus.wrap_count = wrap_q;
      bus.tc         = (bus.up_down && (cnt_q == MAX_VAL)) ||
                       (!bus.up_down && (cnt_q == '0));
   end

endmodule

// File: tb/tb_mod12_updown_counter.sv
module tb_mod12_updown_counter;

   localparam int M      = 12;
   localparam int W      = 4;
   localparam int WW     = 8;
   localparam int WMAX   = (1 << WW) - 1;

   typedef struct {
      int out;
      int carry;
      int borrow;
      int lerr;
      int wrap;
      int tc;
   } exp_t;

   logic clock;
   logic reset;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_cnt = 0;
   int   m_wrap = 0;

   mod12_updown_counter_if #(.WIDTH(W), .WRAP_W(WW)) bus ();

   mod12_updown_counter #(.MODULUS(M), .WIDTH(W), .WRAP_W(WW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge and queue what the
   // following rising edge must produce, computed with plain arithmetic.
   task automatic step(input bit ld, input bit en, input bit ud, input int din);
      exp_t e;
      @(negedge clock);
      bus.load    = ld;
      bus.enable  = en;
      bus.up_down = ud;
      bus.data_in = W'(din);
      e.carry = 0; e.borrow = 0; e.lerr = 0;
      if (ld) begin
         if (din < M) m_cnt = din;
         else begin m_cnt = 0; e.lerr = 1; end
      end else if (en) begin
         if (ud) begin
            if (m_cnt + 1 >= M) e.carry = 1;
            m_cnt = (m_cnt + 1) % M;
         end else begin
            if (m_cnt == 0) e.borrow = 1;
            m_cnt = (m_cnt + M - 1) % M;
         end
      end
      if (e.carry + e.borrow > 0) m_wrap = (m_wrap >= WMAX) ? WMAX : m_wrap + 1;
      e.out  = m_cnt;
      e.wrap = m_wrap;
      e.tc   = ((ud && m_cnt == M - 1) || (!ud && m_cnt == 0)) ? 1 : 0;
      sb_q.push_back(e);
   endtask

   // Monitor: the counter presents a result after every rising edge.
   always @(posedge clock) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("data_out",   int'(bus.data_out),   e.out);
         chk("carry",      int'(bus.carry),      e.carry);
         chk("borrow",     int'(bus.borrow),     e.borrow);
         chk("load_err",   int'(bus.load_err),   e.lerr);
         chk("wrap_count", int'(bus.wrap_count), e.wrap);
         chk("tc",         int'(bus.tc),         e.tc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.enable  = 1'b0;
      bus.up_down = 1'b0;
      bus.data_in = '0;
      #12;
      chk("reset data_out", int'(bus.data_out), 0);
      chk("reset wrap",     int'(bus.wrap_count), 0);
      chk("reset pulses",   int'({bus.carry, bus.borrow, bus.load_err}), 0);
      chk("reset tc",       int'(bus.tc), 1);
      @(negedge clock);
      reset = 1'b0;

      // Count up 13 cycles: 1..11, 0, 1 with one carry.
      for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b1, 0);
      // Load 3, count down 4: 3,2,1,0,11 with a borrow.
      step(1'b1, 1'b0, 1'b0, 3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0);
      // Illegal load then a legal load of the top value.
      step(1'b1, 1'b0, 1'b1, 14);
      step(1'b1, 1'b0, 1'b1, 11);
      // Load wins over enable at the wrap point.
      step(1'b1, 1'b1, 1'b1, 7);
      // Direction change takes effect on the next enabled edge: 5 -> 6 -> 5.
      step(1'b1, 1'b0, 1'b1, 5);
      step(1'b0, 1'b1, 1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 15);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), int'($urandom_range(0, 15)));
      end

      // Asynchronous reset between edges while holding 9.
      step(1'b1, 1'b0, 1'b1, 9);
      @(posedge clock);
      #3;
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.enable  = 1'b0;
      #1;
      chk("async reset data_out", int'(bus.data_out), 0);
      chk("async reset wrap",     int'(bus.wrap_count), 0);
      m_cnt  = 0;
      m_wrap = 0;
      @(negedge clock);
      reset = 1'b0;
      step(1'b0, 1'b1, 1'b1, 0);

      // Free-run up long enough to saturate the tally.
      for (int i = 0; i < M * 260; i++) step(1'b0, 1'b1, 1'b1, 0);
      @(posedge clock);
      #2;
      chk("saturated wrap", int'(bus.wrap_count), WMAX);

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clock);
      #2;
      chk("scoreboard drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
